// File: rtl/reg_file_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sequencer_if
// Description : Bus bundle between reg_file_sequencer and the memories, ALU and
//               register file. Optional perf counters under SEQ_PERF_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_sequencer_if #(
    parameter int PC_WIDTH = 16
);
    logic                run;
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ready;
    logic [31:0]         imem_data;
    logic                dmem_req;
    logic                dmem_we;
    logic                dmem_ready;
    logic                alu_start;
    logic                alu_done;
    logic [31:0]         rf_instr;
    logic [4:0]          rf_addr1;
    logic [4:0]          rf_addr2;
    logic                rf_read_en;
    logic                rf_write_en;
    logic [PC_WIDTH-1:0] pc;
    logic                halted;
    logic                error;
    logic                illegal_op;
`ifdef SEQ_PERF_COUNT_EN
    logic [31:0]         retired_count;
    logic [31:0]         stall_count;
`endif

    modport master (
        input  run, imem_ready, imem_data, dmem_ready, alu_done,
        output imem_req, imem_addr, dmem_req, dmem_we, alu_start, rf_instr,
               rf_addr1, rf_addr2, rf_read_en, rf_write_en, pc, halted, error,
               illegal_op
`ifdef SEQ_PERF_COUNT_EN
        , output retired_count, stall_count
`endif
    );

    modport slave (
        output run, imem_ready, imem_data, dmem_ready, alu_done,
        input  imem_req, imem_addr, dmem_req, dmem_we, alu_start, rf_instr,
               rf_addr1, rf_addr2, rf_read_en, rf_write_en, pc, halted, error,
               illegal_op
`ifdef SEQ_PERF_COUNT_EN
        , input retired_count, stall_count
`endif
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sequencer
// Description : Multi-cycle fetch/decode/execute sequencer for the register
//               file, ALU and memory ports. Perf counters: SEQ_PERF_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sequencer #(
    parameter int PC_WIDTH       = 16,
    parameter int RESET_PC       = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_file_sequencer_if.master bus
);
    localparam logic [3:0] c_st_idle   = 4'd0;
    localparam logic [3:0] c_st_fetch  = 4'd1;
    localparam logic [3:0] c_st_decode = 4'd2;
    localparam logic [3:0] c_st_exec   = 4'd3;
    localparam logic [3:0] c_st_mem    = 4'd4;
    localparam logic [3:0] c_st_wb     = 4'd5;
    localparam logic [3:0] c_st_retire = 4'd6;
    localparam logic [3:0] c_st_halt   = 4'd7;
    localparam logic [3:0] c_st_error  = 4'd8;

    localparam logic [4:0] c_op_lw   = 5'd0;
    localparam logic [4:0] c_op_sw   = 5'd1;
    localparam logic [4:0] c_op_mov  = 5'd2;
    localparam logic [4:0] c_op_add  = 5'd3;
    localparam logic [4:0] c_op_cmp  = 5'd11;
    localparam logic [4:0] c_op_not  = 5'd12;
    localparam logic [4:0] c_op_halt = 5'd31;

    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);

    logic [3:0]          r_state;
    logic [15:0]         r_tcnt;
    logic [PC_WIDTH-1:0] r_pc;
    logic [31:0]         r_rf_instr;
    logic                r_imem_req;
    logic                r_dmem_req;
    logic                r_dmem_we;
    logic                r_alu_start;
    logic                r_rf_read_en;
    logic                r_rf_write_en;
    logic                r_halted;
    logic                r_error;
    logic                r_illegal_op;

    logic [3:0] w_next;
    logic [4:0] w_op;
    logic [4:0] w_fetch_op;
    logic       w_wait;
    logic       w_tmo;
    logic       w_dec_illegal;
    logic       w_fetch_illegal;
    logic       w_fetch_hs;

    always_comb begin
        w_op            = r_rf_instr[31:27];
        w_fetch_op      = bus.imem_data[31:27];
        w_dec_illegal   = (w_op > c_op_not) && (w_op != c_op_halt);
        w_fetch_illegal = (w_fetch_op > c_op_not) && (w_fetch_op != c_op_halt);
        w_fetch_hs      = (r_state == c_st_fetch) && bus.imem_ready;
        // A wait cycle is any cycle in a handshake state whose partner is not ready
        w_wait = ((r_state == c_st_fetch) && !bus.imem_ready) ||
                 ((r_state == c_st_exec)  && !bus.alu_done)   ||
                 ((r_state == c_st_mem)   && !bus.dmem_ready);
        w_tmo  = w_wait && (r_tcnt == c_tmo_last);
        w_next = r_state;
        case (r_state)
            c_st_idle:   if (bus.run) w_next = c_st_fetch;
            c_st_fetch: begin
                if (bus.imem_ready) w_next = c_st_decode;
                else if (w_tmo)     w_next = c_st_error;
            end
            c_st_decode: begin
                if (w_op <= c_op_sw)                         w_next = c_st_mem;
                else if (w_op == c_op_mov)                   w_next = c_st_wb;
                else if (w_op >= c_op_add && w_op <= c_op_not) w_next = c_st_exec;
                else if (w_op == c_op_halt)                  w_next = c_st_halt;
                else                                         w_next = c_st_fetch;
            end
            c_st_exec: begin
                if (bus.alu_done) w_next = (w_op == c_op_cmp) ? c_st_retire : c_st_wb;
                else if (w_tmo)   w_next = c_st_error;
            end
            c_st_mem: begin
                if (bus.dmem_ready) w_next = (w_op == c_op_lw) ? c_st_wb : c_st_retire;
                else if (w_tmo)     w_next = c_st_error;
            end
            c_st_wb:     w_next = c_st_retire;
            c_st_retire: w_next = bus.run ? c_st_fetch : c_st_idle;
            c_st_halt:   w_next = c_st_halt;
            c_st_error:  w_next = c_st_error;
            default:     w_next = c_st_idle;
        endcase
    end

    // Outputs are registered from the next state so they line up with it exactly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_st_idle;
            r_tcnt        <= '0;
            r_pc          <= PC_WIDTH'(RESET_PC);
            r_rf_instr    <= '0;
            r_imem_req    <= 1'b0;
            r_dmem_req    <= 1'b0;
            r_dmem_we     <= 1'b0;
            r_alu_start   <= 1'b0;
            r_rf_read_en  <= 1'b0;
            r_rf_write_en <= 1'b0;
            r_halted      <= 1'b0;
            r_error       <= 1'b0;
            r_illegal_op  <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_tcnt        <= w_wait ? r_tcnt + 16'd1 : 16'd0;
            r_imem_req    <= (w_next == c_st_fetch);
            r_dmem_req    <= (w_next == c_st_mem);
            r_dmem_we     <= (w_next == c_st_mem) && (w_op == c_op_sw);
            r_alu_start   <= (w_next == c_st_exec) && (r_state != c_st_exec);
            r_rf_read_en  <= (w_next == c_st_decode);
            r_rf_write_en <= (w_next == c_st_wb);
            r_halted      <= (w_next == c_st_halt);
            r_error       <= (w_next == c_st_error);
            r_illegal_op  <= w_fetch_hs && w_fetch_illegal;
            if (w_fetch_hs) begin
                r_rf_instr <= bus.imem_data;
            end
            if ((r_state == c_st_retire) || ((r_state == c_st_decode) && w_dec_illegal)) begin
                r_pc <= r_pc + PC_WIDTH'(1);
            end
        end
    end

    assign bus.imem_req    = r_imem_req;
    assign bus.imem_addr   = r_pc;
    assign bus.dmem_req    = r_dmem_req;
    assign bus.dmem_we     = r_dmem_we;
    assign bus.alu_start   = r_alu_start;
    assign bus.rf_instr    = r_rf_instr;
    assign bus.rf_addr1    = r_rf_instr[21:17];
    assign bus.rf_addr2    = r_rf_instr[4:0];
    assign bus.rf_read_en  = r_rf_read_en;
    assign bus.rf_write_en = r_rf_write_en;
    assign bus.pc          = r_pc;
    assign bus.halted      = r_halted;
    assign bus.error       = r_error;
    assign bus.illegal_op  = r_illegal_op;

`ifdef SEQ_PERF_COUNT_EN
    logic [31:0] r_retired_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retired_count <= '0;
            r_stall_count   <= '0;
        end else begin
            if (r_state == c_st_retire) r_retired_count <= r_retired_count + 32'd1;
            if (w_wait)                 r_stall_count   <= r_stall_count + 32'd1;
        end
    end

    assign bus.retired_count = r_retired_count;
    assign bus.stall_count   = r_stall_count;
`endif
endmodule
`default_nettype wire

// File: tb/tb_reg_file_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_sequencer
// Description : Self-checking bench; expected per-cycle outputs are built from
//               instruction-level timing rules and compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_reg_file_sequencer;
    localparam int          PCW = 16;
    localparam logic [15:0] RPC = 16'hFFFE;
    localparam int          TO  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_file_sequencer_if #(.PC_WIDTH(PCW)) bus ();

    reg_file_sequencer #(
        .PC_WIDTH(PCW), .RESET_PC(int'(RPC)), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct packed {
        logic        imem_req;
        logic [15:0] imem_addr;
        logic        dmem_req, dmem_we, alu_start, rd, wr;
        logic [15:0] pc;
        logic        halted, error, illegal;
        logic [31:0] instr;
        logic [4:0]  a1, a2;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        int          fd, md, ad;
    } rec_t;

    vec_t        exp_q[$];
    rec_t        prog[$];
    int          fi = 0;
    int          n_cmp = 0, n_bad = 0;
    logic [15:0] m_pc = RPC;
    logic [31:0] m_instr = '0;
    bit          m_dead = 0;
    int          k_start, k_wr, k_ill, k_dreq, k_dwe, k_ireq, k_halt;

    function automatic rec_t mk(input logic [31:0] instr, input int fd, md, ad);
        rec_t r;
        r.instr = instr; r.fd = fd; r.md = md; r.ad = ad;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic emit(input bit ir, dr, we, st, rd, wr, hl, er, il);
        vec_t v;
        v.imem_req = ir; v.imem_addr = m_pc; v.dmem_req = dr; v.dmem_we = we;
        v.alu_start = st; v.rd = rd; v.wr = wr; v.pc = m_pc; v.halted = hl;
        v.error = er; v.illegal = il; v.instr = m_instr;
        v.a1 = m_instr[21:17]; v.a2 = m_instr[4:0];
        exp_q.push_back(v);
    endtask

    // d unanswered cycles then the answering one, unless the timeout bound is hit first
    task automatic m_wait(input int d, input bit ir, dr, we, st);
        m_dead = (d >= TO);
        for (int i = 0; i < (m_dead ? TO : d + 1); i++)
            emit(ir, dr, we, st && (i == 0), 0, 0, 0, 0, 0);
        if (m_dead) for (int i = 0; i < 6; i++) emit(0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic model_instr(input rec_t r);
        logic [4:0] op;
        bit         ill, wb;
        m_wait(r.fd, 1, 0, 0, 0);
        if (m_dead) return;
        m_instr = r.instr;
        op  = r.instr[31:27];
        ill = (op > 5'd12) && (op != 5'd31);
        emit(0, 0, 0, 0, 1, 0, 0, 0, ill);
        if (ill) begin m_pc++; return; end
        if (op == 5'd31) begin
            m_dead = 1;
            for (int i = 0; i < 20; i++) emit(0, 0, 0, 0, 0, 0, 1, 0, 0);
            return;
        end
        if (op <= 5'd1) begin
            m_wait(r.md, 0, 1, op == 5'd1, 0);
            wb = (op == 5'd0);
        end else if (op == 5'd2) begin
            wb = 1;
        end else begin
            m_wait(r.ad, 0, 0, 0, 1);
            wb = (op != 5'd11);
        end
        if (m_dead) return;
        if (wb) emit(0, 0, 0, 0, 0, 1, 0, 0, 0);
        emit(0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_pc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        drain();
        @(posedge clk); #1;
        rst_n = 0; bus.run = 0;
        @(posedge clk); #1;
        rst_n = 1; m_pc = RPC; m_instr = '0; m_dead = 0;
        emit(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_seg(input int reset_at);
        int   last_fetch;
        vec_t keep;
        drain();
        fi = 0; m_dead = 0;
        k_start = 0; k_wr = 0; k_ill = 0; k_dreq = 0; k_dwe = 0; k_ireq = 0; k_halt = 0;
        emit(0, 0, 0, 0, 0, 0, 0, 0, 0);
        last_fetch = 1;
        foreach (prog[i]) begin
            if (i == prog.size() - 1) last_fetch = exp_q.size();
            if (!m_dead) model_instr(prog[i]);
        end
        if (!m_dead) begin emit(0, 0, 0, 0, 0, 0, 0, 0, 0); emit(0, 0, 0, 0, 0, 0, 0, 0, 0); end
        bus.run = 1;
        for (int cyc = 1; cyc < 400 && exp_q.size() > 0; cyc++) begin
            @(posedge clk); #1;
            if (cyc == last_fetch) bus.run = 0;
            if (cyc == reset_at + 1) begin
                rst_n = 1;
                chk("dmem_req_after_reset", 32'(bus.dmem_req), 32'd0);
            end
            if (cyc == reset_at) begin
                keep = exp_q[0];
                exp_q.delete();
                exp_q.push_back(keep);
                rst_n = 0; bus.run = 0;
                m_pc = RPC; m_instr = '0;
                emit(0, 0, 0, 0, 0, 0, 0, 0, 0);
                emit(0, 0, 0, 0, 0, 0, 0, 0, 0);
            end
        end
        if (exp_q.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL segment_bound: actual=%0d left required=0 left", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Per-cycle compare and pulse counters, sampled mid-cycle
    initial begin
        vec_t e, a;
        forever begin
            @(negedge clk);
            k_start += int'(bus.alu_start === 1'b1);
            k_wr    += int'(bus.rf_write_en === 1'b1);
            k_ill   += int'(bus.illegal_op === 1'b1);
            k_dreq  += int'(bus.dmem_req === 1'b1);
            k_dwe   += int'(bus.dmem_we === 1'b1);
            k_ireq  += int'(bus.imem_req === 1'b1);
            k_halt  += int'(bus.halted === 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.imem_req = bus.imem_req; a.imem_addr = bus.imem_addr;
                a.dmem_req = bus.dmem_req; a.dmem_we = bus.dmem_we;
                a.alu_start = bus.alu_start; a.rd = bus.rf_read_en;
                a.wr = bus.rf_write_en; a.pc = bus.pc; a.halted = bus.halted;
                a.error = bus.error; a.illegal = bus.illegal_op;
                a.instr = bus.rf_instr; a.a1 = bus.rf_addr1; a.a2 = bus.rf_addr2;
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL cycle_outputs t=%0t: actual=%h required=%h", $time, a, e);
                end
            end
        end
    end

    // Memory and ALU responders, each answering after its scripted delay
    initial begin
        bit   pi = 0, pd = 0, aw = 0;
        int   ic = 0, mc = 0, ac = 0, cur = 0;
        rec_t r;
        bus.imem_ready = 0; bus.imem_data = '0; bus.dmem_ready = 0; bus.alu_done = 0;
        forever begin
            @(negedge clk);
            if (bus.imem_req === 1'b1) begin
                if (!pi) begin cur = fi; fi++; ic = 0; end
                else ic++;
            end
            pi = (bus.imem_req === 1'b1);
            if (cur < prog.size()) r = prog[cur];
            else r = mk(32'h0, 1000, 1000, 1000);
            bus.imem_data  = r.instr;
            bus.imem_ready = pi && (ic >= r.fd);
            if (bus.dmem_req === 1'b1) begin
                if (!pd) mc = 0;
                else mc++;
            end
            pd = (bus.dmem_req === 1'b1);
            bus.dmem_ready = pd && (mc >= r.md);
            bus.alu_done = 0;
            if (bus.alu_start === 1'b1) begin aw = 1; ac = 0; end
            else if (aw) ac++;
            if (aw && (ac >= r.ad)) begin bus.alu_done = 1; aw = 0; end
        end
    end

    initial begin
        bus.run = 0;
        repeat (2) @(posedge clk);
        do_reset();
        #1;
        chk("reset_pc", 32'(bus.pc), 32'hFFFE);
        chk("reset_halted", 32'(bus.halted), 32'd0);

        prog.delete(); prog.push_back(mk(32'h18000000, 0, 0, 0));
        run_seg(-10);
        chk("add_pc", 32'(bus.pc), 32'hFFFF);
        chk("add_alu_start_cycles", k_start, 1);
        chk("add_write_cycles", k_wr, 1);

        prog.delete(); prog.push_back(mk(32'h10000000, 0, 0, 0));
        run_seg(-10);
        chk("mov_pc_wrap", 32'(bus.pc), 32'h0000);

        prog.delete(); prog.push_back(mk(32'h00220005, 1, 3, 0));
        run_seg(-10);
        chk("lw_dmem_req_cycles", k_dreq, 4);
        chk("lw_we_cycles", k_dwe, 0);
        chk("lw_write_cycles", k_wr, 1);
        chk("lw_addr1", 32'(bus.rf_addr1), 32'd17);

        prog.delete(); prog.push_back(mk(32'h08000000, 0, 0, 0));
        run_seg(-10);
        chk("sw_we_cycles", k_dwe, 1);
        chk("sw_write_cycles", k_wr, 0);

        prog.delete();
        prog.push_back(mk(32'h58000000, 0, 0, 2));
        prog.push_back(mk(32'hA0000000, 0, 0, 0));
        prog.push_back(mk(32'h20000000, 2, 0, 1));
        run_seg(-10);
        chk("mix_illegal_cycles", k_ill, 1);
        chk("mix_alu_start_cycles", k_start, 2);
        chk("mix_write_cycles", k_wr, 1);
        chk("mix_pc", 32'(bus.pc), 32'h0005);

        prog.delete(); prog.push_back(mk(32'hF8000000, 0, 0, 0));
        run_seg(-10);
        chk("halt_cycles", k_halt, 20);
        chk("halt_fetches", k_ireq, 1);
        chk("halt_pc", 32'(bus.pc), 32'h0005);
        do_reset();
        #1;
        chk("halt_reset_pc", 32'(bus.pc), 32'hFFFE);
        chk("halt_reset_halted", 32'(bus.halted), 32'd0);

        prog.delete(); prog.push_back(mk(32'h18000000, 4, 0, 0));
        run_seg(-10);
        chk("timeout_error", 32'(bus.error), 32'd1);
        chk("timeout_imem_req", 32'(bus.imem_req), 32'd0);
        chk("timeout_fetch_cycles", k_ireq, 4);
        do_reset();

        prog.delete(); prog.push_back(mk(32'h00000000, 0, 3, 0));
        run_seg(4);
        chk("mem_reset_pc", 32'(bus.pc), 32'hFFFE);
        chk("mem_reset_dmem_cycles", k_dreq, 2);

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
